// File: rtl/uart_tx.sv
// UART transmitter fed directly from the TX FIFO.
//
// Takes one byte per frame from the FIFO (fifo_rd strobe, data captured in the same cycle)
// and serialises it as start bit, WIDTH data bits LSB first, optional parity bit and
// STOP_BITS stop bits. Every bit lasts CPB = CLK_FREQ / BAUD clock cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   fifo_data  FIFO head data, valid while fifo_empty = 0
//   fifo_empty FIFO empty flag
//   fifo_rd    FIFO read strobe, one-cycle pulse per byte taken
//   tx_en      transmit enable, only gates the start of a new frame
//   tx         serial output, idles high, always driven from a flop
//   busy       high while a frame is in progress
module uart_tx #(
  parameter int unsigned CLK_FREQ  = 12000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic             tx_en,
  output logic             tx,
  output logic             busy
);

  localparam int unsigned CPB    = CLK_FREQ / BAUD;
  localparam int unsigned CntW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned IdxMax = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
  localparam int unsigned IdxW   = $clog2(IdxMax + 1);

  localparam logic [CntW-1:0] CntLast   = CntW'(CPB - 1);
  localparam logic [IdxW-1:0] DataLast  = IdxW'(WIDTH - 1);
  localparam logic [IdxW-1:0] StopLast  = IdxW'(STOP_BITS - 1);
  localparam bit              HasParity = (PARITY != 0);
  localparam bit              OddParity = (PARITY == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;     // data bit index, reused as stop bit index
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    fifo_rd = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // rst gate keeps the strobe quiet in the reset cycle so no byte is lost.
        if (tx_en && !fifo_empty && !rst) begin
          fifo_rd = 1'b1;
          shift_d = fifo_data;
          par_d   = (^fifo_data) ^ OddParity;
          state_d = StStart;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == DataLast) begin
            state_d = HasParity ? StPar : StStop;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StPar: begin
        if (bit_end) begin
          state_d = StStop;
          idx_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (idx_q == StopLast) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The line level is decoded from the next state so tx is a plain flop output.
    unique case (state_d)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      StPar:   tx_d = par_d;
      StStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no parity / even+2 stop / odd+2 stop), all
// at CPB = 4. A queue models the TX FIFO of the first instance and a line monitor decodes
// its output frames for comparison against the bytes pushed.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] fifo_data0;
  logic       fifo_empty0, fifo_rd0, tx_en0, tx0, busy0;
  logic [7:0] fifo_data1;
  logic       fifo_empty1, tx_en1, tx_en2;
  logic       fifo_rd1, tx1, busy1, fifo_rd2, tx2, busy2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fq[$];      // FIFO contents for dut0
  logic [7:0] exp_q[$];   // bytes that must appear on tx0
  logic [7:0] rx_q[$];    // bytes decoded from tx0
  logic       rd_seen0, rd_seen1, rd_seen2, rd_last0;

  uart_tx #(
    .CLK_FREQ(12000000), .BAUD(3000000), .WIDTH(8), .PARITY(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst(rst), .fifo_data(fifo_data0), .fifo_empty(fifo_empty0),
    .fifo_rd(fifo_rd0), .tx_en(tx_en0), .tx(tx0), .busy(busy0)
  );

  uart_tx #(
    .CLK_FREQ(12000000), .BAUD(3000000), .WIDTH(8), .PARITY(1), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .rst(rst), .fifo_data(fifo_data1), .fifo_empty(fifo_empty1),
    .fifo_rd(fifo_rd1), .tx_en(tx_en1), .tx(tx1), .busy(busy1)
  );

  uart_tx #(
    .CLK_FREQ(12000000), .BAUD(3000000), .WIDTH(8), .PARITY(2), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .rst(rst), .fifo_data(fifo_data1), .fifo_empty(fifo_empty1),
    .fifo_rd(fifo_rd2), .tx_en(tx_en2), .tx(tx2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line monitor for dut0: start bit seen at count 0, each bit sampled mid-cell.
  int         mon_cnt    = 0;
  logic       mon_active = 1'b0;
  logic [7:0] mon_byte   = 8'h00;
  int         mon_err    = 0;

  always @(negedge clk) begin : monitor
    int n;
    int k;
    if (!mon_active) begin
      if (tx0 === 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 0;
      end
    end else begin
      n = mon_cnt + 1;
      k = n / 4;
      mon_cnt <= n;
      if (busy0 !== 1'b1) begin
        mon_active <= 1'b0;  // frame aborted by reset
      end else if (n % 4 == 2) begin
        if (k == 0) begin
          if (tx0 !== 1'b0) mon_err <= mon_err + 1;
        end else if (k <= 8) begin
          mon_byte[k-1] <= tx0;
        end else begin
          if (tx0 !== 1'b1) mon_err <= mon_err + 1;
          rx_q.push_back(mon_byte);
          mon_active <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty0 = (fq.size() == 0);
    fifo_data0  = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] b, input bit expect_out);
    fq.push_back(b);
    if (expect_out) exp_q.push_back(b);
    refresh();
  endtask

  // One clock: called at a negedge, returns at the next negedge. Read strobes are sampled
  // just before the active edge and pop the FIFO model after it.
  task automatic step();
    #1;
    rd_seen0 = fifo_rd0;
    rd_seen1 = fifo_rd1;
    rd_seen2 = fifo_rd2;
    chk("rd_while_empty0", {31'd0, fifo_rd0 & fifo_empty0}, 0);
    chk("rd_consecutive0", {31'd0, fifo_rd0 & rd_last0}, 0);
    chk("rd_while_empty12", {31'd0, (fifo_rd1 | fifo_rd2) & fifo_empty1}, 0);
    rd_last0 = fifo_rd0;
    @(posedge clk);
    #1;
    if (rd_seen0 && fq.size() > 0) void'(fq.pop_front());
    refresh();
    @(negedge clk);
  endtask

  function automatic logic sel_tx(input int sel);
    case (sel)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic sel_busy(input int sel);
    case (sel)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic sel_rd(input int sel);
    case (sel)
      0:       return rd_seen0;
      1:       return rd_seen1;
      default: return rd_seen2;
    endcase
  endfunction

  task automatic wait_rd(input int sel, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (sel_rd(sel)) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_rd_timeout"}, {31'd0, found}, 1);
  endtask

  // Called at the negedge of frame cycle 0; bits[i] is the i-th bit on the line.
  task automatic check_frame(input int sel, input logic [11:0] bits, input int nbits,
                             input int en_off_at, input string tag);
    int rds = 0;
    for (int c = 0; c < nbits * 4; c++) begin
      chk($sformatf("%s_tx@%0d", tag, c), {31'd0, sel_tx(sel)}, {31'd0, bits[c/4]});
      chk($sformatf("%s_busy@%0d", tag, c), {31'd0, sel_busy(sel)}, 1);
      if (c == en_off_at) tx_en0 = 1'b0;
      step();
      if (sel_rd(sel)) rds++;
    end
    chk({tag, "_idle_tx"}, {31'd0, sel_tx(sel)}, 1);
    chk({tag, "_idle_busy"}, {31'd0, sel_busy(sel)}, 0);
    chk({tag, "_rd_in_frame"}, rds, 0);
  endtask

  initial begin
    int rds;
    rst         = 1'b1;
    tx_en0      = 1'b0;
    tx_en1      = 1'b0;
    tx_en2      = 1'b0;
    fifo_data1  = 8'h00;
    fifo_empty1 = 1'b1;
    rd_last0    = 1'b0;
    refresh();
    @(negedge clk);
    repeat (3) step();

    // Reset state
    chk("rst_tx0", {31'd0, tx0}, 1);
    chk("rst_busy0", {31'd0, busy0}, 0);
    chk("rst_rd0", {31'd0, fifo_rd0}, 0);
    chk("rst_tx1", {31'd0, tx1}, 1);
    chk("rst_tx2", {31'd0, tx2}, 1);
    rst = 1'b0;
    step();

    // Single byte 0xA5: 0,1,0,1,0,0,1,0,1,1
    tx_en0 = 1'b1;
    push(8'hA5, 1'b1);
    wait_rd(0, "a5");
    check_frame(0, 12'b0011_0100_1010, 10, -1, "a5");

    // Back-to-back 0x00, 0xFF, 0x3C with a single idle cycle between frames
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    push(8'h3C, 1'b1);
    wait_rd(0, "b2b");
    check_frame(0, 12'b0010_0000_0000, 10, -1, "b00");
    step();
    chk("b2b_gap1_rd", {31'd0, rd_seen0}, 1);
    check_frame(0, 12'b0011_1111_1110, 10, -1, "bff");
    step();
    chk("b2b_gap2_rd", {31'd0, rd_seen0}, 1);
    check_frame(0, 12'b0010_0111_1000, 10, -1, "b3c");

    // Even parity, two stop bits, 0x07: parity 1
    fifo_data1  = 8'h07;
    fifo_empty1 = 1'b0;
    tx_en1      = 1'b1;
    wait_rd(1, "par_even");
    fifo_empty1 = 1'b1;
    tx_en1      = 1'b0;
    check_frame(1, 12'b1110_0000_1110, 12, -1, "par_even");

    // Odd parity, same byte: parity 0
    fifo_empty1 = 1'b0;
    tx_en2      = 1'b1;
    wait_rd(2, "par_odd");
    fifo_empty1 = 1'b1;
    tx_en2      = 1'b0;
    check_frame(2, 12'b1100_0000_1110, 12, -1, "par_odd");

    // Empty FIFO with tx_en=1: line stays idle
    rds = 0;
    for (int i = 0; i < 200; i++) begin
      chk("empty_idle_tx", {31'd0, tx0}, 1);
      step();
      if (rd_seen0) rds++;
    end
    chk("empty_no_rd", rds, 0);

    // tx_en=0 with data waiting: nothing read
    tx_en0 = 1'b0;
    push(8'h81, 1'b1);
    push(8'h42, 1'b1);
    rds = 0;
    repeat (20) begin
      step();
      if (rd_seen0) rds++;
    end
    chk("en_off_no_rd", rds, 0);

    // Drop tx_en during the data bits of 0x81: frame completes, 0x42 waits
    tx_en0 = 1'b1;
    wait_rd(0, "x81");
    check_frame(0, 12'b0011_0000_0010, 10, 8, "x81");
    rds = 0;
    repeat (30) begin
      chk("en_drop_idle_tx", {31'd0, tx0}, 1);
      step();
      if (rd_seen0) rds++;
    end
    chk("en_drop_no_rd", rds, 0);
    tx_en0 = 1'b1;
    wait_rd(0, "x42");
    check_frame(0, 12'b0010_1000_0100, 10, -1, "x42");

    // Reset during data bit 3 of 0xC3
    push(8'hC3, 1'b0);
    wait_rd(0, "xc3");
    repeat (17) step();
    rst = 1'b1;
    step();
    chk("midrst_tx", {31'd0, tx0}, 1);
    chk("midrst_busy", {31'd0, busy0}, 0);
    chk("midrst_rd", {31'd0, fifo_rd0}, 0);
    rst = 1'b0;
    push(8'h5A, 1'b1);
    wait_rd(0, "x5a");
    check_frame(0, 12'b0010_1011_0100, 10, -1, "x5a");

    // Random soak through the FIFO model
    for (int i = 0; i < 500; i++) begin
      push(8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 80)) step();
    end
    for (int i = 0; i < 40000 && (fq.size() != 0 || busy0); i++) step();
    chk("soak_drained", {31'd0, (fq.size() == 0) && !busy0}, 1);
    repeat (10) step();

    chk("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("rx_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    end
    chk("mon_frame_err", mon_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
